regbank_wr_ctrl: RTL and testbench
==================================

# regbank_wr_ctrl

Write-port controller for the 8 x 16-bit register bank. After reset it sequences the bank's initialisation (r[i] = i). It then arbitrates the bank's single write port between two writeback requesters with valid/ready handshakes, and keeps a per-register pending-write scoreboard for hazard detection. It sits between the pipeline writeback stages and the bank's writeAdd/writeData/writeEnable inputs.

## Interface
Parameters:
- DATA_W, 16, register width
- ADDR_W, 3, register address width
- NREGS, 8, register count (2**ADDR_W)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid / req0_ready  in / out  1  requester 0 handshake (ALU writeback)
- req0_addr / req0_data  in  ADDR_W / DATA_W  requester 0 target and value
- req1_valid / req1_ready  in / out  1  requester 1 handshake (load writeback)
- req1_addr / req1_data  in  ADDR_W / DATA_W  requester 1 target and value
- issue_valid  in  1  decode issued an instruction that will write issue_addr
- issue_addr  in  ADDR_W  destination being marked pending
- busy  out  NREGS  pending-write bit per register
- rf_we  out  1  to bank writeEnable
- rf_waddr  out  ADDR_W  to bank writeAdd
- rf_wdata  out  DATA_W  to bank writeData
- init_done  out  1  high once initialisation completes

## Operation
- States: INIT, RUN.
- Reset asserted, asynchronously:
  - state=INIT, init counter=0, rr pointer=0 (req0 favoured).
  - rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, busy=0.
  - req0_ready and req1_ready are 0 throughout INIT.
- INIT: one write per cycle, rf_waddr=cnt, rf_wdata=cnt zero-extended, for cnt=0..NREGS-1.
  - After cnt=NREGS-1 the state moves to RUN and init_done goes to 1.
  - Requests and issue_valid are ignored in INIT.
- RUN, arbitration:
  - Exactly one requester is granted per cycle.
  - Only one valid: it is granted.
  - Both valid: the requester selected by the rr pointer is granted, and the pointer toggles to the other requester.
  - Pointer is unchanged when at most one is valid.
- reqN_ready = RUN and grant to N; it is combinational from the valids and the pointer.
- Transfer = valid and ready in the same cycle. A requester holds its addr/data stable until the transfer.
- Scoreboard (RUN only):
  - issue_valid sets busy[issue_addr].
  - A transfer clears busy[granted addr].
  - Set and clear of the same address in the same cycle: set wins.
  - A write to an address that is not busy is legal and leaves busy unchanged.
- Both requesters targeting the same address in one cycle are serialised in rr order; the last write wins in the bank.
- Reset mid-INIT or mid-RUN aborts the operation immediately; INIT restarts from cnt=0 after reset is released.

## Timing
- rf_we/rf_waddr/rf_wdata are registered: a transfer in cycle t drives the bank in cycle t+1.
- INIT occupies exactly NREGS cycles after the first rising edge with reset high. init_done rises on the edge that ends the last INIT write.
- The first grant is possible in the first RUN cycle.
- busy updates are registered and visible the cycle after issue or transfer.
- Throughput: one write per cycle sustained; each requester gets at least every second slot under contention.

## Configuration
- REGBANK_SCOREBOARD_EN:
  - Defined: the busy scoreboard is implemented as described.
  - Undefined: the scoreboard logic is removed, busy is tied to 0, and issue_valid/issue_addr are ignored. Arbitration and INIT are unaffected.

## Structure
- Shared package regbank_pkg holds:
  - DATA_W, ADDR_W and NREGS constants
  - state enum {INIT, RUN}
  - requester index type
- Sub-module rr_arb2: two-request round-robin arbiter with registered pointer. Inputs are enable and two valids; outputs are a one-hot grant.
- Everything else stays in regbank_wr_ctrl.

## Test plan
- Release reset → rf_we=1 for 8 cycles with (addr,data)=(0,0),(1,1)…(7,7), then init_done=1. Any req0_valid during INIT sees ready=0.
- RUN, req0 only, addr=3, data=0xBEEF → req0_ready=1 the same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0xBEEF.
- Both valid for 4 cycles → grants go req0, req1, req0, req1, and rf_waddr alternates accordingly.
- issue_valid with addr=5 → busy[5]=1 next cycle. A req1 write to 5 clears it. Issue to 5 plus write to 5 in the same cycle keeps busy[5]=1.
- Reset pulsed low mid-RUN with busy=0x24 and a write pending → busy=0, rf_we=0, init_done=0 immediately; INIT reruns in full.
- Build without REGBANK_SCOREBOARD_EN → busy stays 0 under the issue stimulus above, and all other checks pass.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank write-port controller.
// Latency: n/a (types only). Backpressure: n/a.
package regbank_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
// Latency: combinational grant; pointer updates on the edge after contention.
// Backpressure: exactly one grant when any request is valid and en is high.
module rr_arb2
    import regbank_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       vld0,
    input  logic       vld1,
    output logic [1:0] gnt
);

    req_idx_e ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (vld0 && vld1) begin
                // Contention: serve the favoured side, then favour the other.
                gnt   = (ptr_q == REQ0) ? 2'b01 : 2'b10;
                ptr_d = (ptr_q == REQ0) ? REQ1 : REQ0;
            end else begin
                gnt = {vld1, vld0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regbank_wr_ctrl.sv
// Register-bank write port: post-reset init (r[i]=i), 2-way RR writeback arbitration, pending-write scoreboard (REGBANK_SCOREBOARD_EN).
// Latency: grant is combinational, the bank write is registered (transfer in t drives the bank in t+1).
// Backpressure: both readys low during INIT; in RUN one valid requester is granted every cycle.
module regbank_wr_ctrl #(
    parameter int DATA_W = regbank_pkg::DATA_W,
    parameter int ADDR_W = regbank_pkg::ADDR_W,
    parameter int NREGS  = regbank_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [NREGS-1:0]  busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);
    import regbank_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              run;
    logic [1:0]        gnt;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    assign run = (state_q == ST_RUN);

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .vld0  (req0_valid),
        .vld1  (req1_valid),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign xfer       = |gnt;
    assign win_addr   = gnt[1] ? req1_addr : req0_addr;
    assign win_data   = gnt[1] ? req1_data : req0_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (state_q)
            ST_INIT: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = {{(DATA_W-ADDR_W){1'b0}}, cnt_q};
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(NREGS-1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = win_addr;
                    rf_wdata_d = win_data;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef REGBANK_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q, busy_d;

    // Clear first, then set, so an issue to the address being written wins.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (xfer) begin
                busy_d[win_addr] = 1'b0;
            end
            if (issue_valid) begin
                busy_d[issue_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    assign busy = '0;
`endif

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign init_done = run;

endmodule

// File: tb/tb_regbank_wr_ctrl.sv
// Randomized and directed bench for regbank_wr_ctrl; expected bank writes are queued at issue and
// checked by an independent monitor, with readys and busy compared against a behavioural model.
module tb_regbank_wr_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_addr = '0, req1_addr = '0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_addr = '0;
    logic [7:0]  busy;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        init_done;

    regbank_wr_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy        (busy),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    // Model state: which side wins the next contended cycle, and the pending-write set.
    int   next_contended_winner = 0;
    logic [7:0] busy_m = '0;
    int   last_w = 0;
    bit   last_any = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every bank write must be one the bench expects, in order.
    always @(negedge clk) begin
        if (reset && rf_we) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got write addr %0d data 0x%0h, required none", rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(rf_waddr), 32'(mon_e.a));
                check("wr_data", 32'(rf_wdata), 32'(mon_e.d));
            end
        end
    end

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                        input logic v1, input logic [2:0] a1, input logic [15:0] d1,
                        input logic iv, input logic [2:0] ia);
        int  w;
        bit  any;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        issue_valid = iv; issue_addr = ia;
        #3;
        any = v0 || v1;
        w = 0;
        if (v0 && v1) begin
            w = next_contended_winner;
            next_contended_winner = 1 - next_contended_winner;
        end else if (v1) begin
            w = 1;
        end
        check("req0_ready", 32'(req0_ready), 32'(any && w == 0));
        check("req1_ready", 32'(req1_ready), 32'(any && w == 1));
        check("busy", 32'(busy), 32'(busy_m));
        if (any) exp_q.push_back('{a: (w == 1) ? a1 : a0, d: (w == 1) ? d1 : d0});
`ifdef REGBANK_SCOREBOARD_EN
        if (any) busy_m[(w == 1) ? a1 : a0] = 1'b0;
        if (iv) busy_m[ia] = 1'b1;
`endif
        last_w = w;
        last_any = any;
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; asserts reset immediately and runs the full INIT sequence.
    task automatic apply_reset();
        reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'($urandom_range(0, 1));
        #1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", 32'(rf_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        exp_q.delete();
        next_contended_winner = 0;
        busy_m = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) exp_q.push_back('{a: 3'(i), d: 16'(i)});
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_addr = 3'($urandom); req1_addr = 3'($urandom);
            issue_valid = 1'b1;
            issue_addr = 3'($urandom);
            #3;
            check("init_req0_ready", 32'(req0_ready), 32'd0);
            check("init_req1_ready", 32'(req1_ready), 32'd0);
            check("init_done_low", 32'(init_done), 32'd0);
            @(posedge clk); #1;
        end
        check("init_done_high", 32'(init_done), 32'd1);
        check("init_busy", 32'(busy), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; issue_valid = 1'b0;
    endtask

    initial begin
        logic        v0, v1, h0, h1, iv;
        logic [2:0]  a0, a1, ia;
        logic [15:0] d0, d1;

        @(posedge clk); #1;
        apply_reset();

        step(1, 3'd3, 16'hBEEF, 0, 3'd0, 16'h0, 0, 3'd0);
        for (int i = 0; i < 4; i++) step(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 0, 3'd0);
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd5);
        step(0, 3'd0, 16'h0, 1, 3'd5, 16'hCAFE, 0, 3'd0);
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd5);
        step(0, 3'd0, 16'h0, 1, 3'd5, 16'hD00D, 1, 3'd5);
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'd0);
        step(0, 3'd0, 16'h0, 1, 3'd5, 16'h5555, 0, 3'd0);
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'd0);

        // Random traffic; a requester that lost arbitration holds its request.
        h0 = 0; h1 = 0; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!h0) begin
                v0 = 1'($urandom_range(0, 1)); a0 = 3'($urandom); d0 = 16'($urandom);
            end
            if (!h1) begin
                v1 = 1'($urandom_range(0, 2) != 0); a1 = 3'($urandom); d1 = 16'($urandom);
            end
            iv = 1'($urandom_range(0, 2) == 0);
            ia = 3'($urandom);
            step(v0, a0, d0, v1, a1, d1, iv, ia);
            h0 = v0 && !(last_any && last_w == 0);
            h1 = v1 && !(last_any && last_w == 1);
        end
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'd0);

        // Mid-RUN reset with busy = 0x24 and a write on the bank port.
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'd0);
        for (int r = 0; r < 8; r++) step(0, 3'd0, 16'h0, 1, 3'(r), 16'h0, 0, 3'd0);
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd5);
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 3'd2);
        step(1, 3'd0, 16'h1234, 0, 3'd0, 16'h0, 0, 3'd0);
        check("pre_rst_busy", 32'(busy), 32'(busy_m));
        check("pre_rst_rf_we", 32'(rf_we), 32'd1);
        apply_reset();

        step(0, 3'd0, 16'h0, 1, 3'd6, 16'hA5A5, 1, 3'd6);
        step(1, 3'd6, 16'h5A5A, 1, 3'd7, 16'h7777, 0, 3'd0);
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'd0);
        step(0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 3'd0);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
